// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the load/store port, one transaction at a time.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_wmask,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_ack,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic       PORT_INST = 1'b0;
  localparam logic [2:0] CNT_INIT  = 3'(MEM_LATENCY - 1);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       port_q;
  logic       grant;
  logic       grant_data;
  logic [2:0] wait_cnt;

  always_comb begin
    grant      = 1'b0;
    grant_data = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          // On a tie the port that did not win last time goes first.
          grant_data = d_req && (!i_req || (last_grant == PORT_INST));
          state_nxt  = ISSUE;
        end
      end
      // mem_wmask holds the latched mask only during ISSUE.
      ISSUE:   state_nxt = (mem_wmask != 4'b0000) ? DONE : WAIT;
      WAIT:    if (wait_cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_INST;
      port_q     <= PORT_INST;
      wait_cnt   <= 3'd0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= 32'd0;
      d_rdata    <= 32'd0;
      mem_en     <= 1'b0;
      mem_wmask  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
    end else begin
      state     <= state_nxt;
      mem_en    <= grant;
      mem_wmask <= (grant && grant_data) ? d_wmask : 4'b0000;
      i_ack     <= (state_nxt == DONE) && (port_q == PORT_INST);
      d_ack     <= (state_nxt == DONE) && (port_q != PORT_INST);

      if (grant) begin
        last_grant <= grant_data;
        port_q     <= grant_data;
        mem_addr   <= grant_data ? d_addr : i_addr;
        if (grant_data) mem_wdata <= d_wdata;
      end

      if (state == ISSUE) wait_cnt <= CNT_INIT;
      else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;

      if ((state == WAIT) && (wait_cnt == 3'd0)) begin
        if (port_q == PORT_INST) i_rdata <= mem_rdata;
        else d_rdata <= mem_rdata;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: three instances at memory
// latencies 2, 1 and 8, each backed by a latency-exact memory model.
module tb_unified_mem_arbiter;
  localparam int AW = 16;
  localparam int N  = 3;

  typedef struct {
    bit          is_d;
    bit          is_rd;
    logic [31:0] data;
    int          at;
  } exp_t;

  logic          clk = 1'b0;
  int            cyc = 0;
  logic          reset     [N];
  logic          i_req     [N];
  logic [AW-1:0] i_addr    [N];
  logic [31:0]   i_rdata   [N];
  logic          i_ack     [N];
  logic          d_req     [N];
  logic [AW-1:0] d_addr    [N];
  logic [3:0]    d_wmask   [N];
  logic [31:0]   d_wdata   [N];
  logic [31:0]   d_rdata   [N];
  logic          d_ack     [N];
  logic          mem_en    [N];
  logic [AW-1:0] mem_addr  [N];
  logic [3:0]    mem_wmask [N];
  logic [31:0]   mem_wdata [N];
  logic [31:0]   mem_rdata [N];
  logic          busy      [N];

  logic [255:0]  ov_v   [N];
  logic [31:0]   ov_d   [N][256];
  logic [7:0]    sh_v   [N];
  logic [31:0]   sh_d   [N][8];
  logic          en_prev[N];
  logic          dbl    [N];

  exp_t          sbq[$];
  logic [31:0]   exp_ird[N];
  logic [31:0]   exp_drd[N];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    unified_mem_arbiter #(
      .ADDR_WIDTH (AW),
      .MEM_LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 8))
    ) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_rdata  (i_rdata[g]),
      .i_ack    (i_ack[g]),
      .d_req    (d_req[g]),
      .d_addr   (d_addr[g]),
      .d_wmask  (d_wmask[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_ack    (d_ack[g]),
      .mem_en   (mem_en[g]),
      .mem_addr (mem_addr[g]),
      .mem_wmask(mem_wmask[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
  endfunction

  function automatic logic [31:0] base(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 32'h00500093 : ({a, ~a} ^ 32'h13579BDF);
  endfunction

  function automatic logic [31:0] rd_model(input int k, input logic [AW-1:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return ov_v[k][idx] ? ov_d[k][idx] : base(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // Memory model: stores commit at the issue edge, reads appear for exactly
  // one cycle MEM_LATENCY cycles after the issue cycle, junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (cyc == 0) begin
        ov_v[k]    <= '0;
        sh_v[k]    <= '0;
        en_prev[k] <= 1'b0;
        dbl[k]     <= 1'b0;
      end else begin
        if ((mem_en[k] === 1'b1) && (mem_wmask[k] != 4'd0)) begin
          ov_v[k][mem_addr[k][9:2]] <= 1'b1;
          ov_d[k][mem_addr[k][9:2]] <= merge(rd_model(k, mem_addr[k]), mem_wdata[k], mem_wmask[k]);
        end
        sh_v[k]    <= {sh_v[k][6:0], (mem_en[k] === 1'b1) && (mem_wmask[k] == 4'd0)};
        en_prev[k] <= (mem_en[k] === 1'b1);
        if ((mem_en[k] === 1'b1) && en_prev[k]) dbl[k] <= 1'b1;
      end
      sh_d[k][0] <= rd_model(k, mem_addr[k]);
      for (int i = 1; i < 8; i++) sh_d[k][i] <= sh_d[k][i-1];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      mem_rdata[k] = {16'hBAD0, 16'(cyc)};
      if (sh_v[k][lat_of(k)-1]) mem_rdata[k] = sh_d[k][lat_of(k)-1];
    end
  end

  task automatic drive_txn(input int k, input bit is_d, input logic [AW-1:0] a,
                           input logic [3:0] wm, input logic [31:0] wd);
    exp_t e;
    @(posedge clk); #1;
    if (is_d) begin
      d_req[k] = 1'b1; d_addr[k] = a; d_wmask[k] = wm; d_wdata[k] = wd;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = a;
    end
    e.is_d  = is_d;
    e.is_rd = !is_d || (wm == 4'd0);
    e.data  = e.is_rd ? rd_model(k, a) : exp_drd[k];
    e.at    = cyc + (e.is_rd ? lat_of(k) + 2 : 2);
    sbq.push_back(e);
  endtask

  task automatic collect(input int k, input int max_cyc, input bit drop);
    exp_t e;
    bit   got = 1'b0;
    for (int n = 0; n < max_cyc && !got; n++) begin
      @(negedge clk);
      if ((i_ack[k] === 1'b1) || (d_ack[k] === 1'b1)) begin
        got = 1'b1;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ack k=%0d cyc=%0d i_ack=%b d_ack=%b required none", k, cyc, i_ack[k], d_ack[k]);
        end else begin
          e = sbq.pop_front();
          if ({i_ack[k], d_ack[k]} !== {!e.is_d, e.is_d}) begin
            n_bad++;
            $display("FAIL ack_port k=%0d cyc=%0d got {i,d}=%b%b required %b%b", k, cyc, i_ack[k], d_ack[k], !e.is_d, e.is_d);
          end
          n_cmp++;
          if (cyc != e.at) begin
            n_bad++;
            $display("FAIL ack_cycle k=%0d got %0d required %0d", k, cyc, e.at);
          end
          n_cmp++;
          if ((e.is_d ? d_rdata[k] : i_rdata[k]) !== e.data) begin
            n_bad++;
            $display("FAIL rdata k=%0d port=%s got %h required %h", k, e.is_d ? "d" : "i",
                     e.is_d ? d_rdata[k] : i_rdata[k], e.data);
          end
          n_cmp++;
          if ((e.is_d ? i_rdata[k] : d_rdata[k]) !== (e.is_d ? exp_ird[k] : exp_drd[k])) begin
            n_bad++;
            $display("FAIL other_rdata k=%0d got %h required %h", k, e.is_d ? i_rdata[k] : d_rdata[k],
                     e.is_d ? exp_ird[k] : exp_drd[k]);
          end
          if (e.is_rd && e.is_d) exp_drd[k] = e.data;
          if (e.is_rd && !e.is_d) exp_ird[k] = e.data;
          if (drop) begin
            if (e.is_d) d_req[k] = 1'b0;
            else i_req[k] = 1'b0;
          end
        end
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout k=%0d cyc=%0d got no ack required one within %0d cycles", k, cyc, max_cyc);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      reset[k] = 1'b1; i_req[k] = 1'b0; d_req[k] = 1'b0; i_addr[k] = '0;
      d_addr[k] = '0; d_wmask[k] = '0; d_wdata[k] = '0;
      exp_ird[k] = '0; exp_drd[k] = '0;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if ({i_ack[k], d_ack[k], mem_en[k], busy[k], mem_wmask[k]} !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_ctrl k=%0d got ack/en/busy/wmask=%b%b%b%b%b required 0", k, i_ack[k], d_ack[k], mem_en[k], busy[k], mem_wmask[k]);
      end
      n_cmp++;
      if ({i_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset_data k=%0d got irdata=%h drdata=%h addr=%h wdata=%h required 0", k, i_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) reset[k] = 1'b0;
  endtask

  task automatic test_fetch();
    drive_txn(0, 1'b0, 16'h0040, 4'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_t0 got busy=%b mem_en=%b required 0 0", busy[0], mem_en[0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_en[0], mem_addr[0], mem_wmask[0], busy[0]} !== {1'b1, 16'h0040, 4'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL fetch_issue got en=%b addr=%h wmask=%b busy=%b required 1 0040 0000 1", mem_en[0], mem_addr[0], mem_wmask[0], busy[0]);
    end
    collect(0, 25, 1'b1);
    n_cmp++;
    if (i_rdata[0] !== 32'h00500093) begin
      n_bad++;
      $display("FAIL fetch_value got %h required 00500093", i_rdata[0]);
    end
  endtask

  task automatic test_store();
    logic [31:0] b;
    drive_txn(0, 1'b1, 16'h0080, 4'd0, 32'd0);
    collect(0, 25, 1'b1);
    drive_txn(0, 1'b1, 16'h0100, 4'b0011, 32'hDEADBEEF);
    @(posedge clk); #1;
    d_addr[0] = 16'h0200; d_wdata[0] = 32'h0; d_wmask[0] = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if ({mem_en[0], mem_addr[0], mem_wmask[0], mem_wdata[0]} !== {1'b1, 16'h0100, 4'b0011, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL store_issue got en=%b addr=%h wmask=%b wdata=%h required 1 0100 0011 deadbeef", mem_en[0], mem_addr[0], mem_wmask[0], mem_wdata[0]);
    end
    collect(0, 10, 1'b1);
    b = base(16'h0100);
    drive_txn(0, 1'b1, 16'h0100, 4'd0, 32'd0);
    collect(0, 25, 1'b1);
    n_cmp++;
    if (d_rdata[0] !== {b[31:16], 16'hBEEF}) begin
      n_bad++;
      $display("FAIL store_readback got %h required %h", d_rdata[0], {b[31:16], 16'hBEEF});
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   t0;
    int   acks = 0;
    @(posedge clk); #1;
    reset[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b0; exp_ird[0] = '0; exp_drd[0] = '0;
    i_req[0] = 1'b1; i_addr[0] = 16'h0040;
    d_req[0] = 1'b1; d_addr[0] = 16'h0084; d_wmask[0] = 4'd0;
    t0 = cyc;
    for (int j = 0; j < 4; j++) begin
      e.is_d  = (j % 2 == 0);
      e.is_rd = 1'b1;
      e.data  = e.is_d ? rd_model(0, 16'h0084) : 32'h00500093;
      e.at    = t0 + 4 + 5 * j;
      sbq.push_back(e);
    end
    for (int j = 0; j < 4; j++) collect(0, 30, 1'b0);
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (i_ack[0] === 1'b1 || d_ack[0] === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL contention_tail got acks=%0d busy=%b required 0 0", acks, busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   t0;
    @(posedge clk); #1;
    i_req[1] = 1'b1; i_addr[1] = 16'h0044;
    t0 = cyc;
    for (int j = 0; j < 4; j++) begin
      e.is_d = 1'b0; e.is_rd = 1'b1; e.data = rd_model(1, 16'h0044); e.at = t0 + 3 + 4 * j;
      sbq.push_back(e);
    end
    for (int j = 0; j < 3; j++) collect(1, 20, 1'b0);
    collect(1, 20, 1'b1);
    n_cmp++;
    if (dbl[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL mem_en_double got consecutive mem_en=%b required 0", dbl[1]);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    @(posedge clk); #1;
    i_req[0] = 1'b1; i_addr[0] = 16'h0048;
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b1; i_req[0] = 1'b0;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({i_ack[0], d_ack[0], mem_en[0], busy[0], mem_wmask[0], i_rdata[0], d_rdata[0], mem_addr[0], mem_wdata[0]} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs got ack=%b%b en=%b busy=%b wmask=%b ird=%h drd=%h addr=%h wdata=%h required 0",
               i_ack[0], d_ack[0], mem_en[0], busy[0], mem_wmask[0], i_rdata[0], d_rdata[0], mem_addr[0], mem_wdata[0]);
    end
    exp_ird[0] = '0; exp_drd[0] = '0;
    repeat (12) begin
      @(negedge clk);
      if (i_ack[0] === 1'b1 || d_ack[0] === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++;
      $display("FAIL reset_mid_ack got %0d acks required 0", acks);
    end
    drive_txn(0, 1'b0, 16'h004C, 4'd0, 32'd0);
    collect(0, 25, 1'b1);
  endtask

  task automatic test_latency();
    drive_txn(1, 1'b0, 16'h0050, 4'd0, 32'd0);
    collect(1, 20, 1'b1);
    drive_txn(1, 1'b1, 16'h0054, 4'd0, 32'd0);
    collect(1, 20, 1'b1);
    drive_txn(2, 1'b1, 16'h0060, 4'd0, 32'd0);
    collect(2, 30, 1'b1);
    drive_txn(2, 1'b0, 16'h0040, 4'd0, 32'd0);
    collect(2, 30, 1'b1);
    drive_txn(2, 1'b1, 16'h0064, 4'b1000, 32'hA5000000);
    collect(2, 30, 1'b1);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no completion required finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port. Each requester uses a req/ack handshake. The arbiter latches the winning request and issues it to memory for exactly one cycle. It then waits a fixed memory latency, captures read data and returns it to the requester with a one-cycle ack. Ties are resolved round-robin so neither fetch nor data traffic starves.

## Interface
- ADDR_WIDTH, 16, byte-address width of all address buses
- MEM_LATENCY, 1, cycles from the memory-issue cycle to `mem_rdata` valid; legal range 1..8
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  ADDR_WIDTH  instruction address
- i_rdata  out  32  instruction read data
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_ack
- d_addr  in  ADDR_WIDTH  data address
- d_wmask  in  4  byte write mask; 0 = load, nonzero = store
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wmask  out  4  memory byte write mask
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the mem_en cycle
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port opposite `last_grant`. `last_grant` resets to INST, so the first tie goes to DATA.
  - On a grant: latch port id, address, wmask (forced to 0 for INST) and wdata; update `last_grant`; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive mem_en=1 and mem_addr/mem_wmask/mem_wdata from the latched values.
  - If the latched wmask is nonzero (store), go to DONE.
  - Otherwise load the wait counter with MEM_LATENCY-1 and go to WAIT.
- WAIT (MEM_LATENCY cycles):
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0, capture mem_rdata into i_rdata or d_rdata (by latched port) at the closing edge, then go to DONE.
- DONE (exactly 1 cycle): pulse ack on the latched port, then go to IDLE.
- Outside ISSUE: mem_en=0 and mem_wmask=0. mem_addr and mem_wdata hold their last latched value.
- i_rdata and d_rdata change only on a completed read for their own port. A store never alters d_rdata.
- Request inputs are sampled only in IDLE. Address, data or mask changes after the grant are ignored.
- Protocol rules:
  - The requester holds req through the ack cycle.
  - A req still high in the cycle after ack is treated as a new request.
  - If req drops before ack, the transaction still completes and ack still pulses.
- Reset values: state=IDLE, last_grant=INST, i_ack=d_ack=0, i_rdata=d_rdata=0, mem_en=0, mem_wmask=0, mem_addr=0, mem_wdata=0, busy=0.
- Reset mid-transaction:
  - The FSM returns to IDLE next cycle and no ack is issued for the aborted transaction.
  - A store already presented in ISSUE is not undone.
- Counter is 3 bits, sufficient for MEM_LATENCY up to 8.

## Timing
- Request seen in IDLE at cycle T0. ISSUE (mem_en) occurs at T0+1.
- Load or fetch: ack at T0+MEM_LATENCY+2, with rdata valid in the same cycle.
- Store: ack at T0+2.
- The earliest next grant is the cycle after DONE, so back-to-back reads are spaced MEM_LATENCY+3 cycles ack-to-ack.
- All outputs are registered except busy, which is decoded from state.
- mem_en is never high for two consecutive cycles.
- Only one transaction is ever outstanding.

## Test plan
- Single fetch, MEM_LATENCY=2: i_req at cycle 0 with i_addr=0x0040; memory returns 0x00500093. Required: mem_en=1 with mem_addr=0x0040 at cycle 1; i_ack=1 and i_rdata=0x00500093 at cycle 4; d_ack stays 0.
- Store: d_req with d_addr=0x0100, d_wmask=4'b0011, d_wdata=0xDEADBEEF at cycle 0. Required: mem_en=1, mem_wmask=4'b0011, mem_wdata=0xDEADBEEF at cycle 1; d_ack at cycle 2; d_rdata unchanged.
- Contention after reset: both reqs held continuously for 4 transactions. Required: grant order DATA, INST, DATA, INST; each ack delivered only to its own port.
- Fetch held high continuously, MEM_LATENCY=1. Required: i_ack every 4 cycles; mem_en never asserted on two consecutive cycles.
- Reset asserted during WAIT. Required: no ack; all outputs at their reset values the following cycle; a new i_req is then serviced with normal latency.
- Latency sweep at MEM_LATENCY=1 and 8. Required: load ack at T0+3 and T0+10 respectively, and the captured data equals mem_rdata exactly MEM_LATENCY cycles after the mem_en cycle.
